// File: rtl/bounce_generator_pkg.sv
// Shared definitions for the bounce generator: FSM state encodings,
// LFSR tap constant and the LFSR next-state helper.
package bounce_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One step of the 16-bit Galois LFSR: shift right, fold taps in when the
    // bit shifted out is set.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR, reusable by any stimulus block that needs
// a cheap deterministic pseudo-random source.
module lfsr16
    import bounce_generator_pkg::*;
#(
    parameter logic [15:0] p_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    // Advance every cycle; reset reloads the (nonzero) seed.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            state <= p_SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/bounce_generator.sv
// Switch-bounce imitator: on an accepted level request it chatters the output
// with gaps shorter than a same-width debouncer's tolerance, then settles at
// the requested level and holds it for T+1 cycles before accepting again.
module bounce_generator
    import bounce_generator_pkg::*;
#(
    parameter int          p_CNT_WIDTH  = 2,
    parameter logic        p_INIT_VALUE = 1'b0,
    parameter int          p_BOUNCES    = 3,
    parameter logic [15:0] p_SEED       = 16'hACE1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  logic i_level,
    output logic o_ready,
    output logic o_out,
    output logic o_settled
);

    // Debouncer tolerance in cycles and counter widths.
    localparam int lp_T        = 1 << p_CNT_WIDTH;
    localparam int lp_TGL_W    = $clog2(2 * p_BOUNCES + 2);
    localparam int lp_SETTLE_W = p_CNT_WIDTH + 1;

    // Index of the final toggle (toggles are counted from zero).
    localparam logic [lp_TGL_W-1:0]    lp_LAST_TOGGLE = lp_TGL_W'(2 * p_BOUNCES);
    localparam logic [lp_SETTLE_W-1:0] lp_SETTLE_END  = lp_SETTLE_W'(lp_T);
    localparam logic [p_CNT_WIDTH-1:0] lp_GAP_ONE     = p_CNT_WIDTH'(1);

    logic [15:0]            w_lfsr;
    logic [p_CNT_WIDTH-1:0] w_gap_raw;
    logic [p_CNT_WIDTH-1:0] w_gap;
    logic                   w_unused_lfsr;

    state_t                 r_state;
    logic                   r_out;
    logic                   r_ready;
    logic                   r_settled;
    logic                   r_target;
    logic [p_CNT_WIDTH-1:0] r_gap;
    logic [lp_TGL_W-1:0]    r_toggle_cnt;
    logic [lp_SETTLE_W-1:0] r_settle_cnt;

    lfsr16 #(
        .p_SEED (p_SEED)
    ) u_lfsr (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .state (w_lfsr)
    );

    // Gap to the next toggle: low LFSR bits, with zero promoted to one so the
    // gap always lies in 1..T-1 and can never reach the debouncer tolerance.
    assign w_gap_raw     = w_lfsr[p_CNT_WIDTH-1:0];
    assign w_gap         = (w_gap_raw == '0) ? lp_GAP_ONE : w_gap_raw;
    // Upper LFSR bits only feed the sequence itself, not the gap.
    assign w_unused_lfsr = ^w_lfsr;

    // Single FSM: IDLE accepts requests, BOUNCE emits 2*p_BOUNCES+1 toggles,
    // SETTLE holds the final level T+1 cycles before returning to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_out        <= p_INIT_VALUE;
            r_ready      <= 1'b1;
            r_settled    <= 1'b0;
            r_target     <= p_INIT_VALUE;
            r_gap        <= '0;
            r_toggle_cnt <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_settled <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (i_level == r_out) begin
                            // Already at the requested level: just acknowledge.
                            r_settled <= 1'b1;
                        end else begin
                            // Gap of one makes the first toggle land on the next edge.
                            r_target     <= i_level;
                            r_state      <= ST_BOUNCE;
                            r_ready      <= 1'b0;
                            r_gap        <= lp_GAP_ONE;
                            r_toggle_cnt <= '0;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (r_gap == lp_GAP_ONE) begin
                        r_gap <= w_gap;
                        if (r_toggle_cnt == lp_LAST_TOGGLE) begin
                            // Odd toggle count already lands on target; driving it
                            // explicitly keeps the final level robust.
                            r_out        <= r_target;
                            r_state      <= ST_SETTLE;
                            r_settle_cnt <= '0;
                        end else begin
                            r_out        <= ~r_out;
                            r_toggle_cnt <= r_toggle_cnt + 1'b1;
                        end
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == lp_SETTLE_END) begin
                        r_state   <= ST_IDLE;
                        r_ready   <= 1'b1;
                        r_settled <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_out     = r_out;
    assign o_settled = r_settled;

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench for bounce_generator: a bouncing instance (width 2,
// three bounce pairs) chained into a behavioural debouncer, plus a clean-edge
// instance (width 1, no bounces, initial level 1).
module tb_bounce_generator;

    localparam int A_T = 4;
    localparam int A_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst_n, a_valid, a_level, a_ready, a_out, a_settled;
    logic b_rst_n, b_valid, b_level, b_ready, b_out, b_settled;

    int n_tests = 0;
    int n_fail  = 0;

    bounce_generator #(
        .p_CNT_WIDTH (2), .p_INIT_VALUE (1'b0), .p_BOUNCES (3), .p_SEED (16'hACE1)
    ) u_dut_a (
        .i_clk (clk), .i_rst_n (a_rst_n), .i_valid (a_valid), .i_level (a_level),
        .o_ready (a_ready), .o_out (a_out), .o_settled (a_settled)
    );

    bounce_generator #(
        .p_CNT_WIDTH (1), .p_INIT_VALUE (1'b1), .p_BOUNCES (0), .p_SEED (16'h1D2B)
    ) u_dut_b (
        .i_clk (clk), .i_rst_n (b_rst_n), .i_valid (b_valid), .i_level (b_level),
        .o_ready (b_ready), .o_out (b_out), .o_settled (b_settled)
    );

    // Reference LFSR: right shift, xor taps 0xB400 when a one falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Reference LFSR value that the DUT will use at the coming edge.
    logic [15:0] m_a_lfsr;
    always @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) m_a_lfsr <= 16'hACE1;
        else          m_a_lfsr <= lfsr_step(m_a_lfsr);
    end

    // Width-2 debouncer: output follows input after T consecutive differing samples.
    logic a_db;
    int   db_cnt;
    always @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            a_db   <= 1'b0;
            db_cnt <= 0;
        end else if (a_out !== a_db) begin
            if (db_cnt == A_T - 1) begin
                a_db   <= a_out;
                db_cnt <= 0;
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end else begin
            db_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One request on DUT A, checked cycle by cycle against a toggle schedule
    // derived from the gap rule and the reference LFSR.
    task automatic req_a(input bit level, input bit busy, output int toggles, output int db_changes);
        logic [15:0] l;
        logic        start, prev_out, prev_db, exp_out;
        int          offs[$];
        int          off, ready_off, idx, g;
        toggles    = 0;
        db_changes = 0;
        for (int w = 0; w < 200 && a_ready !== 1'b1; w++) @(negedge clk);
        check("req_ready", a_ready, 1);
        start   = a_out;
        prev_db = a_db;
        l       = m_a_lfsr;
        a_valid = 1'b1;
        a_level = level;
        @(posedge clk); #1;
        a_valid = 1'b0;
        if (level == start) begin
            check("same_settled", a_settled, 1);
            check("same_ready", a_ready, 1);
            check("same_out", a_out, start);
            @(posedge clk); #1;
            check("same_pulse_end", a_settled, 0);
            check("same_hold", a_out, start);
            if (a_db !== prev_db) db_changes++;
            return;
        end
        check("accept_ready_low", a_ready, 0);
        check("accept_no_toggle", a_out, start);
        if (busy) begin
            a_valid = 1'b1;
            a_level = 1'($urandom_range(0, 1));
        end
        // Toggle schedule: first at +1, then each gap from the LFSR at that edge.
        l   = lfsr_step(l);
        off = 1;
        for (int i = 0; i < 2 * A_B + 1; i++) begin
            offs.push_back(off);
            if (i < 2 * A_B) begin
                g = int'(l) % A_T;
                if (g == 0) g = 1;
                for (int s = 0; s < g; s++) l = lfsr_step(l);
                off += g;
            end
        end
        ready_off = off + A_T + 1;
        idx       = 0;
        prev_out  = start;
        for (int n = 1; n <= ready_off; n++) begin
            @(posedge clk); #1;
            while (idx < offs.size() && offs[idx] <= n) idx++;
            exp_out = start ^ idx[0];
            check("bounce_out", a_out, exp_out);
            check("bounce_ready", a_ready, (n == ready_off));
            check("bounce_settled", a_settled, (n == ready_off));
            if (a_out !== prev_out) toggles++;
            prev_out = a_out;
            if (a_db !== prev_db) db_changes++;
            prev_db = a_db;
            if (n == offs[offs.size() - 1]) check("deb_quiet_in_chatter", a_db, start);
            if (busy && n < ready_off) begin
                a_valid = 1'b1;
                a_level = 1'($urandom_range(0, 1));
            end else begin
                a_valid = 1'b0;
            end
        end
    endtask

    typedef struct {
        bit level;
        bit busy;
        int exp_toggles;
        bit exp_final;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  t, d, exp_t;
        bit  lvl;

        vecs[0] = '{level: 1'b1, busy: 1'b0, exp_toggles: 7, exp_final: 1'b1};
        vecs[1] = '{level: 1'b1, busy: 1'b0, exp_toggles: 0, exp_final: 1'b1};
        vecs[2] = '{level: 1'b0, busy: 1'b1, exp_toggles: 7, exp_final: 1'b0};
        vecs[3] = '{level: 1'b0, busy: 1'b0, exp_toggles: 0, exp_final: 1'b0};
        vecs[4] = '{level: 1'b1, busy: 1'b1, exp_toggles: 7, exp_final: 1'b1};
        vecs[5] = '{level: 1'b0, busy: 1'b0, exp_toggles: 7, exp_final: 1'b0};

        a_rst_n = 1'b0; a_valid = 1'b0; a_level = 1'b0;
        b_rst_n = 1'b0; b_valid = 1'b0; b_level = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_b_out", b_out, 1);
            check("rst_b_ready", b_ready, 1);
            check("rst_b_settled", b_settled, 0);
            check("rst_a_out", a_out, 0);
            check("rst_a_ready", a_ready, 1);
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Clean edge on B: one toggle at k+1, ready back three cycles later.
        @(negedge clk);
        b_valid = 1'b1; b_level = 1'b0;
        @(posedge clk); #1;
        b_valid = 1'b0;
        check("clean_accept_ready", b_ready, 0);
        check("clean_accept_out", b_out, 1);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            check("clean_out", b_out, 0);
            check("clean_ready", b_ready, (n >= 4));
            check("clean_settled", b_settled, (n == 4));
        end
        // Same-level request on B.
        b_valid = 1'b1; b_level = 1'b0;
        @(posedge clk); #1;
        b_valid = 1'b0;
        check("clean_same_settled", b_settled, 1);
        check("clean_same_ready", b_ready, 1);
        @(posedge clk); #1;
        check("clean_same_pulse_end", b_settled, 0);
        check("clean_same_out", b_out, 0);

        // Table-driven requests on A, back-to-back.
        foreach (vecs[i]) begin
            req_a(vecs[i].level, vecs[i].busy, t, d);
            check("vec_toggles", t, vecs[i].exp_toggles);
            check("vec_final_out", a_out, vecs[i].exp_final);
            check("vec_deb_changes", d, (vecs[i].exp_toggles != 0));
            check("vec_deb_final", a_db, vecs[i].exp_final);
        end

        // Reset in the middle of BOUNCE.
        a_valid = 1'b1; a_level = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_first_toggle", a_out, 1);
        #2 a_rst_n = 1'b0;
        #1;
        check("mid_rst_out", a_out, 0);
        check("mid_rst_ready", a_ready, 1);
        check("mid_rst_settled", a_settled, 0);
        @(negedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", a_out, 0);
            check("post_rst_ready", a_ready, 1);
        end
        req_a(1'b1, 1'b0, t, d);
        check("post_rst_toggles", t, 7);
        check("post_rst_final", a_out, 1);

        // Debouncer chain: alternating requests.
        for (int i = 0; i < 20; i++) begin
            lvl = ~a_out;
            req_a(lvl, 1'($urandom_range(0, 1)), t, d);
            check("alt_toggles", t, 7);
            check("alt_final_out", a_out, lvl);
            check("alt_deb_changes", d, 1);
            check("alt_deb_final", a_db, lvl);
        end

        // Random levels, including same-level requests.
        for (int i = 0; i < 20; i++) begin
            lvl   = 1'($urandom_range(0, 1));
            exp_t = (lvl != a_out) ? 7 : 0;
            req_a(lvl, 1'($urandom_range(0, 1)), t, d);
            check("rnd_toggles", t, exp_t);
            check("rnd_final_out", a_out, lvl);
            check("rnd_deb_changes", d, (exp_t != 0));
            check("rnd_deb_final", a_db, lvl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
